mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares one external memory channel among `NUM_CONSUMERS` LSUs or fetchers. It uses the same valid/ready consumer handshake as the existing memory controller. Per-consumer grant fairness is guaranteed by a rotating priority pointer. It sits between a core's LSU array and a single-channel memory port, and can optionally abort requests that memory never answers.

## Interface
- `ADDR_BITS`, 8, memory address width.
- `DATA_BITS`, 16, memory data width.
- `NUM_CONSUMERS`, 4, number of requesters; any value ≥1, including non-power-of-two.
- `TIMEOUT_CYCLES`, 64, waiting-cycle limit; used only with `MEM_ARB_TIMEOUT_EN`; must be ≥2.
- `CW`: local width = max(1, $clog2(`NUM_CONSUMERS`)).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `consumer_read_valid` in [N]: read requests.
- `consumer_read_address` in ADDR_BITS ×N: read addresses.
- `consumer_read_ready` out [N]: read response ready.
- `consumer_read_data` out DATA_BITS ×N: read response data.
- `consumer_write_valid` in [N]: write requests.
- `consumer_write_address` in ADDR_BITS ×N: write addresses.
- `consumer_write_data` in DATA_BITS ×N: write data.
- `consumer_write_ready` out [N]: write acknowledges.
- `mem_read_valid` out 1; `mem_read_address` out ADDR_BITS; `mem_read_ready` in 1; `mem_read_data` in DATA_BITS.
- `mem_write_valid` out 1; `mem_write_address` out ADDR_BITS; `mem_write_data` out DATA_BITS; `mem_write_ready` in 1.
- `grant_id` out CW: consumer currently or last served.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_error` out [N]: sticky per-consumer abort flags.

## Operation
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Registers: `rr_ptr` (CW bits, reset 0) and `cur` (CW bits).
- IDLE arbitration:
  - Scan consumers `rr_ptr`, `rr_ptr`+1, … in order, wrapping from N-1 to 0.
  - The first consumer with read or write valid wins.
  - Within one consumer, read beats write.
- On a grant:
  - `cur` ← sel, `grant_id` ← sel, `rr_ptr` ← (sel+1) mod N.
  - Read: latch address, set `mem_read_valid`, go to READ_WAITING.
  - Write: latch address and data, set `mem_write_valid`, go to WRITE_WAITING.
- READ_WAITING, on `mem_read_ready`: clear `mem_read_valid`, set `consumer_read_ready[cur]`, capture `consumer_read_data[cur]` ← `mem_read_data`, go to READ_RELAYING.
- WRITE_WAITING, on `mem_write_ready`: clear `mem_write_valid`, set `consumer_write_ready[cur]`, go to WRITE_RELAYING.
- READ_RELAYING, when `consumer_read_valid[cur]` is low: clear the ready, go to IDLE.
- WRITE_RELAYING, when `consumer_write_valid[cur]` is low: clear the ready, go to IDLE.
- Consumer address and data are sampled only at grant; later changes are ignored.
- `consumer_read_data` holds its last value until overwritten.
- Only one request is ever in flight.

## Timing
- All outputs are registered.
- Reset values:
  - All valid and ready bits are 0.
  - All addresses and data outputs are 0.
  - `grant_id` = 0, `busy` = 0, `timeout_error` = 0, `rr_ptr` = 0, state = IDLE.
- Reset mid-transaction drops the in-flight request with no response.
- A request present at clock edge k produces memory valid after edge k.
- Memory ready sampled at edge m produces consumer ready after edge m.
- Consumer valid sampled low at edge r returns the block to IDLE after edge r. The next grant is evaluated at edge r+1, so there is one idle cycle between transactions.
- Worst-case wait for a held request is N-1 other transactions.
- With N=1, `rr_ptr` stays 0.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to a WAITING state and increments each WAITING cycle.
  - If it reaches `TIMEOUT_CYCLES`-1 with memory ready still low:
    - Clear the memory valid.
    - Set the consumer's ready; for a read, data ← 0.
    - Set `timeout_error[cur]`, which stays set until reset.
    - Go to the matching RELAYING state.
  - If memory ready is high on the timeout cycle, memory ready wins and no error is flagged.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter is built; WAITING lasts indefinitely.
  - `timeout_error` is tied to 0.

## Test plan
- Reset, then single read from consumer 2 at 0x1A; memory answers 0xBEEF after 3 cycles → `mem_read_address` = 0x1A; `consumer_read_ready[2]`=1 and `consumer_read_data[2]`=0xBEEF one cycle after memory ready; state returns to IDLE one cycle after valid drops.
- All 4 consumers hold read valid continuously → grant order 0,1,2,3,0; `rr_ptr` ends at 1.
- Consumer 1 asserts read and write simultaneously → read served first, then consumers 2, 3, 0, then consumer 1's write.
- Write from consumer 3 with 0x44/0x1234 → `mem_write_address`=0x44, `mem_write_data`=0x1234; `consumer_write_ready[3]` asserted after memory ready.
- `MEM_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8 and memory never ready → consumer 0 receives ready with data 0, `timeout_error`=4'b0001; without the macro, WAITING persists beyond 100 cycles.
- Reset asserted while in READ_WAITING → next cycle all outputs are 0 and the block is IDLE.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one memory channel among NUM_CONSUMERS requesters.
// Optional abort of unanswered requests is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic [CW-1:0]                      grant_id,
  output logic                               busy,
  output logic [NUM_CONSUMERS-1:0]           timeout_error
);

  localparam int CWP = CW + 1;

  localparam logic [2:0] S_IDLE           = 3'd0;
  localparam logic [2:0] S_READ_WAITING   = 3'd1;
  localparam logic [2:0] S_WRITE_WAITING  = 3'd2;
  localparam logic [2:0] S_READ_RELAYING  = 3'd3;
  localparam logic [2:0] S_WRITE_RELAYING = 3'd4;

  logic [2:0]                         state_r;
  logic [CW-1:0]                      rr_ptr_r;
  logic [CW-1:0]                      cur_r;
  logic [CW-1:0]                      grant_id_r;
  logic                               busy_r;
  logic                               mem_read_valid_r;
  logic [ADDR_BITS-1:0]               mem_read_address_r;
  logic                               mem_write_valid_r;
  logic [ADDR_BITS-1:0]               mem_write_address_r;
  logic [DATA_BITS-1:0]               mem_write_data_r;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_r;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_r;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_r;

  logic          found_s;
  logic          sel_read_s;
  logic [CW-1:0] sel_s;
  logic [CW-1:0] nxt_ptr_s;
  logic          timeout_hit_s;

  // Rotating-priority scan starting at rr_ptr_r; read beats write within one consumer
  always_comb begin
    logic [CW:0] idx_v;
    found_s    = 1'b0;
    sel_read_s = 1'b0;
    sel_s      = {CW{1'b0}};
    idx_v      = {CWP{1'b0}};
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx_v = {1'b0, rr_ptr_r} + CWP'(i);
      if (idx_v >= CWP'(NUM_CONSUMERS)) begin
        idx_v = idx_v - CWP'(NUM_CONSUMERS);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && (consumer_read_valid[idx_v[CW-1:0]] || consumer_write_valid[idx_v[CW-1:0]])) begin
        found_s    = 1'b1;
        sel_s      = idx_v[CW-1:0];
        sel_read_s = consumer_read_valid[idx_v[CW-1:0]];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer advances past the winner, wrapping at NUM_CONSUMERS
  always_comb begin
    if (sel_s == CW'(NUM_CONSUMERS - 1)) begin
      nxt_ptr_s = {CW{1'b0}};
    end else begin
      nxt_ptr_s = sel_s + CW'(1);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0]            tmo_cnt_r;
  logic [NUM_CONSUMERS-1:0] timeout_error_r;

  assign timeout_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_error = timeout_error_r;

  // Waiting-cycle counter (zero on every entry to a waiting state) and sticky abort flags
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r       <= {TW{1'b0}};
      timeout_error_r <= {NUM_CONSUMERS{1'b0}};
    end else if ((state_r == S_READ_WAITING && !mem_read_ready) ||
                 (state_r == S_WRITE_WAITING && !mem_write_ready)) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
      if (timeout_hit_s) begin
        timeout_error_r[cur_r] <= 1'b1;
      end
    end else begin
      tmo_cnt_r <= {TW{1'b0}};
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_error = {NUM_CONSUMERS{1'b0}};
`endif

  // Transaction sequencer: grant, wait for memory, relay response until the consumer drops valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r                <= S_IDLE;
      rr_ptr_r               <= {CW{1'b0}};
      cur_r                  <= {CW{1'b0}};
      grant_id_r             <= {CW{1'b0}};
      busy_r                 <= 1'b0;
      mem_read_valid_r       <= 1'b0;
      mem_read_address_r     <= {ADDR_BITS{1'b0}};
      mem_write_valid_r      <= 1'b0;
      mem_write_address_r    <= {ADDR_BITS{1'b0}};
      mem_write_data_r       <= {DATA_BITS{1'b0}};
      consumer_read_ready_r  <= {NUM_CONSUMERS{1'b0}};
      consumer_write_ready_r <= {NUM_CONSUMERS{1'b0}};
      consumer_read_data_r   <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            cur_r      <= sel_s;
            grant_id_r <= sel_s;
            rr_ptr_r   <= nxt_ptr_s;
            busy_r     <= 1'b1;
            if (sel_read_s) begin
              mem_read_address_r <= consumer_read_address[sel_s*ADDR_BITS +: ADDR_BITS];
              mem_read_valid_r   <= 1'b1;
              state_r            <= S_READ_WAITING;
            end else begin
              mem_write_address_r <= consumer_write_address[sel_s*ADDR_BITS +: ADDR_BITS];
              mem_write_data_r    <= consumer_write_data[sel_s*DATA_BITS +: DATA_BITS];
              mem_write_valid_r   <= 1'b1;
              state_r             <= S_WRITE_WAITING;
            end
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid_r                                 <= 1'b0;
            consumer_read_ready_r[cur_r]                     <= 1'b1;
            consumer_read_data_r[cur_r*DATA_BITS +: DATA_BITS] <= mem_read_data;
            state_r                                          <= S_READ_RELAYING;
          end else if (timeout_hit_s) begin
            mem_read_valid_r                                 <= 1'b0;
            consumer_read_ready_r[cur_r]                     <= 1'b1;
            consumer_read_data_r[cur_r*DATA_BITS +: DATA_BITS] <= {DATA_BITS{1'b0}};
            state_r                                          <= S_READ_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready || timeout_hit_s) begin
            mem_write_valid_r             <= 1'b0;
            consumer_write_ready_r[cur_r] <= 1'b1;
            state_r                       <= S_WRITE_RELAYING;
          end
        end
        S_READ_RELAYING: begin
          if (!consumer_read_valid[cur_r]) begin
            consumer_read_ready_r[cur_r] <= 1'b0;
            busy_r                       <= 1'b0;
            state_r                      <= S_IDLE;
          end
        end
        S_WRITE_RELAYING: begin
          if (!consumer_write_valid[cur_r]) begin
            consumer_write_ready_r[cur_r] <= 1'b0;
            busy_r                        <= 1'b0;
            state_r                       <= S_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign consumer_read_ready  = consumer_read_ready_r;
  assign consumer_read_data   = consumer_read_data_r;
  assign consumer_write_ready = consumer_write_ready_r;
  assign mem_read_valid       = mem_read_valid_r;
  assign mem_read_address     = mem_read_address_r;
  assign mem_write_valid      = mem_write_valid_r;
  assign mem_write_address    = mem_write_address_r;
  assign mem_write_data       = mem_write_data_r;
  assign grant_id             = grant_id_r;
  assign busy                 = busy_r;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed stimulus for mem_rr_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]    consumer_read_valid = '0;
  logic [N*AB-1:0] consumer_read_address = '0;
  logic [N-1:0]    consumer_read_ready;
  logic [N*DB-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid = '0;
  logic [N*AB-1:0] consumer_write_address = '0;
  logic [N*DB-1:0] consumer_write_data = '0;
  logic [N-1:0]    consumer_write_ready;
  logic            mem_read_valid;
  logic [AB-1:0]   mem_read_address;
  logic            mem_read_ready = 1'b0;
  logic [DB-1:0]   mem_read_data = '0;
  logic            mem_write_valid;
  logic [AB-1:0]   mem_write_address;
  logic [DB-1:0]   mem_write_data;
  logic            mem_write_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic [N-1:0]    timeout_error;

  mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .grant_id(grant_id), .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  int rd_cnt [N];
  int wr_cnt [N];
  bit mem_en  = 1'b1;
  int lat     = 3;
  int dut_log[$];
  int mdl_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DB-1:0] mem_word(input logic [AB-1:0] a);
    return (a == 8'h1A) ? 16'hBEEF : {~a, a};
  endfunction

  // ---------------- reference model: one transaction at a time, rotating priority ----------------
  typedef enum {M_IDLE, M_RD_WAIT, M_WR_WAIT, M_RD_RESP, M_WR_RESP} mphase_t;
  mphase_t ph = M_IDLE;
  int m_ptr = 0, m_cur = 0, m_wait = 0;
  logic e_mrv = 0, e_mwv = 0, e_busy = 0;
  logic [AB-1:0]   e_mra = '0, e_mwa = '0;
  logic [DB-1:0]   e_mwd = '0;
  logic [N-1:0]    e_crr = '0, e_cwr = '0, e_terr = '0;
  logic [N*DB-1:0] e_crd = '0;
  logic [1:0]      e_gid = '0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      ph = M_IDLE; m_ptr = 0; m_cur = 0; m_wait = 0;
      e_mrv = 0; e_mwv = 0; e_mra = '0; e_mwa = '0; e_mwd = '0;
      e_crr = '0; e_cwr = '0; e_crd = '0; e_gid = '0; e_terr = '0;
    end else begin
      case (ph)
        M_IDLE: begin
          int w;
          w = -1;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && (consumer_read_valid[c] || consumer_write_valid[c])) w = c;
          end
          if (w >= 0) begin
            m_cur = w; e_gid = 2'(w); m_ptr = (w + 1) % N; m_wait = 0;
            if (consumer_read_valid[w]) begin
              mdl_log.push_back(w);
              e_mra = consumer_read_address[w*AB +: AB]; e_mrv = 1; ph = M_RD_WAIT;
            end else begin
              mdl_log.push_back(w + 10);
              e_mwa = consumer_write_address[w*AB +: AB];
              e_mwd = consumer_write_data[w*DB +: DB]; e_mwv = 1; ph = M_WR_WAIT;
            end
          end
        end
        M_RD_WAIT: begin
          if (mem_read_ready) begin
            e_mrv = 0; e_crr[m_cur] = 1; e_crd[m_cur*DB +: DB] = mem_read_data; ph = M_RD_RESP;
          end else if (TMO_EN && m_wait == TMO - 1) begin
            e_mrv = 0; e_crr[m_cur] = 1; e_crd[m_cur*DB +: DB] = '0; e_terr[m_cur] = 1; ph = M_RD_RESP;
          end else m_wait++;
        end
        M_WR_WAIT: begin
          if (mem_write_ready) begin
            e_mwv = 0; e_cwr[m_cur] = 1; ph = M_WR_RESP;
          end else if (TMO_EN && m_wait == TMO - 1) begin
            e_mwv = 0; e_cwr[m_cur] = 1; e_terr[m_cur] = 1; ph = M_WR_RESP;
          end else m_wait++;
        end
        M_RD_RESP: if (!consumer_read_valid[m_cur]) begin e_crr[m_cur] = 0; ph = M_IDLE; end
        M_WR_RESP: if (!consumer_write_valid[m_cur]) begin e_cwr[m_cur] = 0; ph = M_IDLE; end
        default: ph = M_IDLE;
      endcase
    end
    e_busy = (ph != M_IDLE);
  end

  // ---------------- per-cycle compare and DUT grant log ----------------
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_mem_read_valid", 64'(mem_read_valid), 64'(e_mrv));
        chk("cyc_mem_write_valid", 64'(mem_write_valid), 64'(e_mwv));
        chk("cyc_mem_read_address", 64'(mem_read_address), 64'(e_mra));
        chk("cyc_mem_write_address", 64'(mem_write_address), 64'(e_mwa));
        chk("cyc_mem_write_data", 64'(mem_write_data), 64'(e_mwd));
        chk("cyc_consumer_read_ready", 64'(consumer_read_ready), 64'(e_crr));
        chk("cyc_consumer_write_ready", 64'(consumer_write_ready), 64'(e_cwr));
        chk("cyc_consumer_read_data", 64'(consumer_read_data), 64'(e_crd));
        chk("cyc_grant_id", 64'(grant_id), 64'(e_gid));
        chk("cyc_busy", 64'(busy), 64'(e_busy));
        chk("cyc_timeout_error", 64'(timeout_error), 64'(e_terr));
        if ((mem_read_valid | mem_write_valid) === 1'b1 && !prev_v)
          dut_log.push_back(mem_write_valid ? int'(grant_id) + 10 : int'(grant_id));
        prev_v = (mem_read_valid | mem_write_valid) === 1'b1;
      end
    end
  end

  // ---------------- consumers: raise valid while work remains, drop it on ready ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (consumer_read_ready[i] === 1'b1 && consumer_read_valid[i]) begin
        consumer_read_valid[i] = 1'b0; rd_cnt[i]--;
      end else consumer_read_valid[i] = (rd_cnt[i] > 0);
      if (consumer_write_ready[i] === 1'b1 && consumer_write_valid[i]) begin
        consumer_write_valid[i] = 1'b0; wr_cnt[i]--;
      end else consumer_write_valid[i] = (wr_cnt[i] > 0);
    end
  end

  // ---------------- memory: answers after lat cycles of valid, ready for one cycle ----------------
  initial begin
    int rc, wc;
    rc = 0; wc = 0;
    forever begin
      @(negedge clk);
      if (mem_read_ready) mem_read_ready = 1'b0;
      else if (mem_en && mem_read_valid === 1'b1) begin
        rc++;
        if (rc >= lat) begin mem_read_ready = 1'b1; mem_read_data = mem_word(mem_read_address); rc = 0; end
      end else rc = 0;
      if (mem_write_ready) mem_write_ready = 1'b0;
      else if (mem_en && mem_write_valid === 1'b1) begin
        wc++;
        if (wc >= lat) begin mem_write_ready = 1'b1; wc = 0; end
      end else wc = 0;
    end
  end

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += rd_cnt[i] + wr_cnt[i];
    return s;
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 400 && !(pending() == 0 && busy === 1'b0)) begin @(negedge clk); n++; end
    n_tests++;
    if (n >= 400) begin n_fail++; $display("FAIL %s: still busy after %0d cycles, expected idle", name, n); end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_mrv"}, 64'(mem_read_valid), 64'd0);
    chk({name, "_mwv"}, 64'(mem_write_valid), 64'd0);
    chk({name, "_addr"}, 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
    chk({name, "_ready"}, 64'({consumer_read_ready, consumer_write_ready}), 64'd0);
    chk({name, "_rdata"}, 64'(consumer_read_data), 64'd0);
    chk({name, "_gid_busy"}, 64'({grant_id, busy}), 64'd0);
    chk({name, "_terr"}, 64'(timeout_error), 64'd0);
  endtask

  task automatic log_check(input string name, input int exp [5]);
    chk({name, "_dut_len"}, 64'(dut_log.size()), 64'd5);
    chk({name, "_model_len"}, 64'(mdl_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_dut_%0d", name, i), 64'(dut_log.size() > i ? dut_log[i] : -1), 64'(exp[i]));
      chk($sformatf("%s_model_%0d", name, i), 64'(mdl_log.size() > i ? mdl_log[i] : -1), 64'(exp[i]));
    end
  endtask

  task automatic wait_neg(input string name, input int which);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (which == 0 && mem_read_valid === 1'b1) break;
      if (which == 1 && mem_write_valid === 1'b1) break;
      if (which == 2 && consumer_read_ready[0] === 1'b1) break;
      n++;
    end
    n_tests++;
    if (n >= 200) begin n_fail++; $display("FAIL %s: event %0d not seen within %0d cycles", name, which, n); end
  endtask

  task automatic wait_mem_ready(input string name, input bit wr);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      if (!wr && mem_read_ready) break;
      if (wr && mem_write_ready) break;
      n++;
    end
    n_tests++;
    if (n >= 200) begin n_fail++; $display("FAIL %s: memory ready not seen within %0d cycles", name, n); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; end
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check_zero("reset");
    reset = 1'b0;

    // single read from consumer 2 at 0x1A, memory answers 0xBEEF
    consumer_read_address[2*AB +: AB] = 8'h1A;
    rd_cnt[2] = 1;
    wait_neg("t1_grant", 0);
    chk("t1_mem_read_address", 64'(mem_read_address), 64'h1A);
    chk("t1_grant_id", 64'(grant_id), 64'd2);
    wait_mem_ready("t1_mem", 1'b0);
    @(negedge clk);
    chk("t1_read_ready", 64'(consumer_read_ready), 64'b0100);
    chk("t1_read_data", 64'(consumer_read_data[2*DB +: DB]), 64'hBEEF);
    @(negedge clk);
    chk("t1_idle_after_drop", 64'({busy, consumer_read_ready}), 64'd0);
    wait_done("t1_done");

    reset = 1'b1; @(negedge clk); reset = 1'b0;

    // all four consumers read; consumer 0 comes back for a second turn
    for (int i = 0; i < N; i++) consumer_read_address[i*AB +: AB] = 8'(8'h10 + i);
    dut_log.delete(); mdl_log.delete();
    rd_cnt[0] = 2; rd_cnt[1] = 1; rd_cnt[2] = 1; rd_cnt[3] = 1;
    wait_done("t2_done");
    log_check("t2_order", '{0, 1, 2, 3, 0});
    chk("t2_model_ptr", 64'(m_ptr), 64'd1);

    // consumer 1 reads and writes at once with 2, 3, 0 also waiting
    for (int i = 0; i < N; i++) begin
      consumer_write_address[i*AB +: AB] = 8'(8'h60 + i);
      consumer_write_data[i*DB +: DB]    = 16'(16'hC000 + i);
    end
    dut_log.delete(); mdl_log.delete();
    rd_cnt[1] = 1; wr_cnt[1] = 1; rd_cnt[2] = 1; wr_cnt[3] = 1; rd_cnt[0] = 1;
    wait_done("t3_done");
    log_check("t3_order", '{1, 2, 13, 0, 11});

    // write from consumer 3
    consumer_write_address[3*AB +: AB] = 8'h44;
    consumer_write_data[3*DB +: DB]    = 16'h1234;
    wr_cnt[3] = 1;
    wait_neg("t4_grant", 1);
    chk("t4_mem_write_address", 64'(mem_write_address), 64'h44);
    chk("t4_mem_write_data", 64'(mem_write_data), 64'h1234);
    wait_mem_ready("t4_mem", 1'b1);
    @(negedge clk);
    chk("t4_write_ready", 64'(consumer_write_ready), 64'b1000);
    wait_done("t4_done");

    mem_en = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    consumer_read_address[0*AB +: AB] = 8'h77;
    rd_cnt[0] = 1;
    wait_neg("t5_abort", 2);
    chk("t5_abort_data", 64'(consumer_read_data[0 +: DB]), 64'h0);
    chk("t5_timeout_error", 64'(timeout_error), 64'b0001);
    wait_done("t5_done");
    rd_cnt[1] = 1;
    wait_neg("t6_grant", 0);
    repeat (2) @(negedge clk);
`else
    rd_cnt[0] = 1;
    wait_neg("t5_grant", 0);
    repeat (120) @(negedge clk);
    chk("t5_still_waiting", 64'({mem_read_valid, consumer_read_ready}), 64'b10000);
    chk("t5_no_error", 64'(timeout_error), 64'd0);
`endif
    chk("t6_busy_before_reset", 64'(busy), 64'd1);
    for (int i = 0; i < N; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; end
    reset = 1'b1;
    @(negedge clk);
    check_zero("t6_mid_reset");
    reset = 1'b0;
    mem_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_stays_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
